// File: rtl/serial_add_pkg.sv
// serial_add_pkg: shared types and constants for the bit-serial adder.
//   state_t       : controller state encoding (IDLE, RUN, DONE)
//   DEFAULT_WIDTH : default operand/result width in bits
package serial_add_pkg;

  localparam int unsigned DEFAULT_WIDTH = 8;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_RUN  = 2'd1;
  localparam state_t ST_DONE = 2'd2;

endpackage

// File: rtl/full_adder.sv
// full_adder: combinational 1-bit full adder.
//   a, b, cin : input bits
//   sum, cout : sum bit and carry-out
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: computes {cout,sum} = a + b + cin one bit per clock
// through a single full adder, LSB first.
//   clk, rst   : clock, synchronous active-high reset
//   start      : request, accepted only in IDLE
//   a, b, cin  : operands and carry-in, latched on the accepted start edge
//   busy       : high in RUN and DONE
//   done       : one-cycle pulse, result valid
//   sum, cout  : result, held until the next accepted start
//   ovf        : signed overflow (only when SERIAL_ADD_OVF_EN is defined)
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef SERIAL_ADD_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int unsigned       IDX_W    = $clog2(WIDTH);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(WIDTH - 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_sum;
  logic [IDX_W-1:0] r_index;
  logic             r_carry;
  logic             r_cout;
  logic             r_busy;
  logic             r_done;
  logic             w_fa_sum;
  logic             w_fa_cout;
  logic             w_last;

  // Operands shift right so the current bit is always at position 0
  full_adder u_fa (
    .a    (r_a[0]),
    .b    (r_b[0]),
    .cin  (r_carry),
    .sum  (w_fa_sum),
    .cout (w_fa_cout)
  );

  assign w_last = (r_index == LAST_IDX);

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (start)  w_state_nxt = ST_RUN;
      ST_RUN:  if (w_last) w_state_nxt = ST_DONE;
      ST_DONE:             w_state_nxt = ST_IDLE;
      default:             w_state_nxt = ST_IDLE;
    endcase
  end

  // State register; busy/done registered from the next state
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_busy  <= (w_state_nxt != ST_IDLE);
      r_done  <= (w_state_nxt == ST_DONE);
    end
  end

  // Datapath: operand latch, bit-serial accumulation, final carry
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_index <= '0;
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_a     <= a;
            r_b     <= b;
            r_carry <= cin;
            r_index <= '0;
            r_sum   <= '0;
          end
        end
        ST_RUN: begin
          r_sum[r_index] <= w_fa_sum;
          r_carry        <= w_fa_cout;
          r_a            <= r_a >> 1;
          r_b            <= r_b >> 1;
          // Index holds at the last bit so it never wraps
          if (w_last) begin
            r_cout <= w_fa_cout;
          end else begin
            r_index <= r_index + IDX_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

`ifdef SERIAL_ADD_OVF_EN
  logic r_ovf;

  // On the last bit r_carry is the carry into the MSB
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ovf <= 1'b0;
    end else if ((r_state == ST_RUN) && w_last) begin
      r_ovf <= r_carry ^ w_fa_cout;
    end
  end

  assign ovf = r_ovf;
`endif

  assign busy = r_busy;
  assign done = r_done;
  assign sum  = r_sum;
  assign cout = r_cout;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb_serial_add_ctrl: directed and random checks of serial_add_ctrl at
// WIDTH=8 and WIDTH=16, against an arithmetic cycle-count model.
module tb_serial_add_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        cin;
  logic [7:0]  a8, b8;
  logic [15:0] a16, b16;
  logic        busy8, done8, cout8;
  logic [7:0]  sum8;
  logic        busy16, done16, cout16;
  logic [15:0] sum16;
`ifdef SERIAL_ADD_OVF_EN
  logic        ovf8, ovf16;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  always #5 clk = ~clk;

  serial_add_ctrl #(.WIDTH(8)) u_dut8 (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a8),
    .b     (b8),
    .cin   (cin),
    .busy  (busy8),
    .done  (done8),
    .sum   (sum8),
    .cout  (cout8)
`ifdef SERIAL_ADD_OVF_EN
    ,
    .ovf   (ovf8)
`endif
  );

  serial_add_ctrl #(.WIDTH(16)) u_dut16 (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a16),
    .b     (b16),
    .cin   (cin),
    .busy  (busy16),
    .done  (done16),
    .sum   (sum16),
    .cout  (cout16)
`ifdef SERIAL_ADD_OVF_EN
    ,
    .ovf   (ovf16)
`endif
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Model: cycles since the accepted start (0 = idle), result computed
  // arithmetically at the start edge and published on the done cycle.
  int          m_cnt   [2];
  logic [31:0] m_sum   [2];
  logic        m_cout  [2];
  logic        m_ovf   [2];
  logic [31:0] m_psum  [2];
  logic        m_pcout [2];
  logic        m_povf  [2];
  bit          m_valid = 1'b0;

  function automatic int wof(input int i);
    return (i == 0) ? 8 : 16;
  endfunction

  always @(posedge clk) begin
    longint unsigned oa, ob, full, lo, cim;
    int w;
    cyc++;
    for (int i = 0; i < 2; i++) begin
      w  = wof(i);
      oa = (i == 0) ? 64'(a8) : 64'(a16);
      ob = (i == 0) ? 64'(b8) : 64'(b16);
      if (rst) begin
        m_cnt[i]  = 0;
        m_sum[i]  = '0;
        m_cout[i] = 1'b0;
        m_ovf[i]  = 1'b0;
      end else if (m_cnt[i] == 0) begin
        if (start) begin
          full       = oa + ob + 64'(cin);
          lo         = (64'd1 << (w - 1)) - 1;
          cim        = (((oa & lo) + (ob & lo) + 64'(cin)) >> (w - 1)) & 1;
          m_psum[i]  = 32'(full & ((64'd1 << w) - 1));
          m_pcout[i] = 1'((full >> w) & 1);
          m_povf[i]  = 1'(cim) ^ m_pcout[i];
          m_sum[i]   = '0;
          m_cnt[i]   = 1;
        end
      end else if (m_cnt[i] == w + 1) begin
        m_cnt[i] = 0;
      end else begin
        m_cnt[i]++;
        if (m_cnt[i] == w + 1) begin
          m_sum[i]  = m_psum[i];
          m_cout[i] = m_pcout[i];
          m_ovf[i]  = m_povf[i];
        end
      end
    end
    if (rst) m_valid = 1'b1;
  end

  // Per-cycle compare; result outputs are meaningful in IDLE and DONE
  always @(negedge clk) begin
    if (m_valid) begin
      check("busy8", busy8, m_cnt[0] != 0);
      check("done8", done8, m_cnt[0] == 9);
      if (m_cnt[0] == 0 || m_cnt[0] == 9) begin
        check("sum8", sum8, m_sum[0]);
        check("cout8", cout8, m_cout[0]);
`ifdef SERIAL_ADD_OVF_EN
        check("ovf8", ovf8, m_ovf[0]);
`endif
      end
      check("busy16", busy16, m_cnt[1] != 0);
      check("done16", done16, m_cnt[1] == 17);
      if (m_cnt[1] == 0 || m_cnt[1] == 17) begin
        check("sum16", sum16, m_sum[1]);
        check("cout16", cout16, m_cout[1]);
`ifdef SERIAL_ADD_OVF_EN
        check("ovf16", ovf16, m_ovf[1]);
`endif
      end
    end
  end

  // Returns at the negedge of cycle 1 (first RUN cycle)
  task automatic pulse_start(input logic [7:0] av, input logic [7:0] bv, input logic c);
    @(negedge clk);
    a8 = av; b8 = bv; a16 = {bv, av}; b16 = {av, bv}; cin = c; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // lat = cycle index (from the start edge) at which done8 is seen
  task automatic wait_done(input string tag, output int lat, output int nbusy);
    lat = 1; nbusy = 0;
    while (1) begin
      if (busy8) nbusy++;
      if (done8 || lat >= 40) break;
      @(negedge clk);
      lat++;
    end
    check({tag, "_done_seen"}, done8, 1);
  endtask

  task automatic do_op(input string tag, input logic [7:0] av, input logic [7:0] bv,
                       input logic c, input logic [7:0] es, input logic ec);
    int lat, nb;
    pulse_start(av, bv, c);
    wait_done(tag, lat, nb);
    check({tag, "_lat"}, lat, 9);
    check({tag, "_busy_cycles"}, nb, 9);
    check({tag, "_sum"}, sum8, es);
    check({tag, "_cout"}, cout8, ec);
    repeat (12) @(negedge clk);
  endtask

  initial begin
    int lat, nb, ndone, nbusy;
    int dcyc [3];
    rst = 1'b1; start = 1'b0; cin = 1'b0;
    a8 = '0; b8 = '0; a16 = '0; b16 = '0;
    @(negedge clk);
    @(negedge clk);
    check("rst_busy", busy8, 0);
    check("rst_done", done8, 0);
    check("rst_sum", sum8, 0);
    check("rst_cout", cout8, 0);
    rst = 1'b0;

    do_op("add_05_03", 8'h05, 8'h03, 1'b0, 8'h08, 1'b0);
    do_op("add_ff_01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
`ifdef SERIAL_ADD_OVF_EN
    do_op("add_7f_01", 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0);
    check("ovf_7f_01", ovf8, 1);
`endif

    // Operands change during RUN; result must reflect the latched values
    pulse_start(8'hFF, 8'hFF, 1'b1);
    a8 = 8'h00; b8 = 8'h00; a16 = '0; b16 = '0; cin = 1'b0;
    wait_done("ff_ff_1", lat, nb);
    check("ff_ff_1_lat", lat, 9);
    check("ff_ff_1_sum", sum8, 8'hFF);
    check("ff_ff_1_cout", cout8, 1);
    repeat (12) @(negedge clk);

    // start pulses in RUN (cycle 2) and DONE (cycle 9) are dropped
    pulse_start(8'h10, 8'h20, 1'b0);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (6) @(negedge clk);
    check("drop_done_cycle", done8, 1);
    check("drop_sum", sum8, 8'h30);
    start = 1'b1;
    @(negedge clk); start = 1'b0;
    ndone = 0; nbusy = 0;
    repeat (30) begin
      @(negedge clk);
      if (done8) ndone++;
      if (busy8) nbusy++;
    end
    check("drop_extra_done", ndone, 0);
    check("drop_extra_busy", nbusy, 0);

    // start held high: three back-to-back operations
    @(negedge clk);
    a8 = 8'h40; b8 = 8'h41; a16 = 16'h1234; b16 = 16'h4321; cin = 1'b1; start = 1'b1;
    ndone = 0;
    for (int k = 0; k < 80 && ndone < 3; k++) begin
      @(negedge clk);
      if (done8) begin
        dcyc[ndone] = cyc;
        ndone++;
        if (ndone == 3) start = 1'b0;
      end
    end
    start = 1'b0;
    check("held_ndone", ndone, 3);
    check("held_gap1", dcyc[1] - dcyc[0], 10);
    check("held_gap2", dcyc[2] - dcyc[1], 10);
    check("held_sum", sum8, 8'h82);
    repeat (25) @(negedge clk);

    // Reset in the 4th RUN cycle aborts; a fresh start works
    pulse_start(8'h12, 8'h34, 1'b0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_busy", busy8, 0);
    check("abort_done", done8, 0);
    check("abort_sum", sum8, 0);
    check("abort_cout", cout8, 0);
    ndone = 0;
    repeat (20) begin
      @(negedge clk);
      if (done8) ndone++;
    end
    check("abort_no_done", ndone, 0);
    do_op("after_abort", 8'h12, 8'h34, 1'b0, 8'h46, 1'b0);

    // Random operations; operands are scrambled while the adders run
    for (int n = 0; n < 1000; n++) begin
      @(negedge clk);
      a8 = 8'($urandom); b8 = 8'($urandom);
      a16 = 16'($urandom); b16 = 16'($urandom);
      cin = 1'($urandom); start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (17) begin
        @(negedge clk);
        a8 = 8'($urandom); b8 = 8'($urandom);
        a16 = 16'($urandom); b16 = 16'($urandom);
        cin = 1'($urandom);
      end
    end
    repeat (4) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
